diff_pair_receiver: RTL and testbench

Downstream consumer of the differential splitter's `output_Plus` / `output_Minus` pair. It synchronises the pair into one clock domain and decodes each pair state into a symbol. Bits use return-to-idle signalling, and each bit must be qualified by stability. The receiver assembles `WIDTH` bits LSB-first into a word and delivers it over a valid/ready interface. It also flags framing timeouts, illegal both-high faults and dropped words.

---
 rtl/diff_pair_receiver.sv | 175 +++++++++++++++++
 tb/tb_diff_pair_receiver.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/diff_pair_receiver.sv
// diff_pair_receiver: synchronises a differential pair, qualifies
// return-to-idle symbols by stability, and assembles LSB-first words
// delivered over a valid/ready output register.
module diff_pair_receiver #(
  parameter int WIDTH   = 8,
  parameter int HOLD    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pair_p,
  input  logic             pair_n,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overflow,
  input  logic             clr_overflow,
  output logic             frame_err,
  output logic             fault_err
);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(HOLD + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  // Symbol codes as seen on {p, n}
  localparam logic [1:0] SYM_IDLE  = 2'b00;
  localparam logic [1:0] SYM_FAULT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_QUAL, S_RTZ} state_t;

  logic [1:0]       sync_p, sync_n;
  logic [1:0]       sym;
  state_t           state, state_nxt;
  logic [1:0]       cand, cand_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [IW-1:0]    idle_cnt, idle_nxt;
  logic [BW-1:0]    bit_cnt, bit_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             word_done, done_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic             dv_nxt, ovf_nxt, frame_nxt, fault_nxt;

  // Two-flop synchroniser per leg; the symbol comes from the second stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p <= '0;
      sync_n <= '0;
    end else begin
      sync_p <= {sync_p[0], pair_p};
      sync_n <= {sync_n[0], pair_n};
    end
  end

  assign sym = {sync_p[1], sync_n[1]};

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cand       <= '0;
      cnt        <= '0;
      idle_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      word_done  <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
      fault_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cand       <= cand_nxt;
      cnt        <= cnt_nxt;
      idle_cnt   <= idle_nxt;
      bit_cnt    <= bit_nxt;
      shreg      <= shreg_nxt;
      word_done  <= done_nxt;
      data       <= data_nxt;
      data_valid <= dv_nxt;
      overflow   <= ovf_nxt;
      frame_err  <= frame_nxt;
      fault_err  <= fault_nxt;
    end
  end

  // Next-state, symbol qualification and word hand-off
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    idle_nxt  = idle_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    done_nxt  = 1'b0;
    frame_nxt = 1'b0;
    fault_nxt = 1'b0;
    data_nxt  = data;
    dv_nxt    = data_valid;
    ovf_nxt   = overflow;

    case (state)
      S_IDLE: begin
        if (sym == SYM_IDLE) begin
          // Saturating idle count; abort a partial word once on reaching TIMEOUT
          if (idle_cnt != IW'(TIMEOUT)) begin
            idle_nxt = idle_cnt + 1'b1;
            if (idle_cnt == IW'(TIMEOUT - 1) && bit_cnt != '0) begin
              frame_nxt = 1'b1;
              bit_nxt   = '0;
            end
          end
        end else begin
          state_nxt = S_QUAL;
          cand_nxt  = sym;
          cnt_nxt   = CW'(1);
          idle_nxt  = '0;
        end
      end
      S_QUAL: begin
        if (sym == SYM_IDLE) begin
          // Dropped back to idle before qualifying: a glitch, silently ignored
          state_nxt = S_IDLE;
          idle_nxt  = IW'(1);
        end else if (sym != cand) begin
          cand_nxt = sym;
          cnt_nxt  = CW'(1);
        end else if (cnt == CW'(HOLD - 1)) begin
          state_nxt = S_RTZ;
          cnt_nxt   = '0;
          if (cand == SYM_FAULT) begin
            fault_nxt = 1'b1;
            bit_nxt   = '0;
          end else begin
            // 10 -> 1, 01 -> 0, so the bit value is the p leg
            shreg_nxt[bit_cnt] = cand[1];
            if (bit_cnt == BW'(WIDTH - 1)) begin
              bit_nxt  = '0;
              done_nxt = 1'b1;
            end else begin
              bit_nxt = bit_cnt + 1'b1;
            end
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RTZ: begin
        if (sym != SYM_IDLE) begin
          cnt_nxt = '0;
        end else if (cnt == CW'(HOLD - 1)) begin
          state_nxt = S_IDLE;
          idle_nxt  = IW'(HOLD);
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Output register: a completed word loads one cycle after its last bit
    if (data_valid && data_ready) dv_nxt = 1'b0;
    if (clr_overflow) ovf_nxt = 1'b0;
    if (word_done) begin
      if (!data_valid || data_ready) begin
        data_nxt = shreg;
        dv_nxt   = 1'b1;
      end else begin
        ovf_nxt = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_diff_pair_receiver.sv
// Directed self-checking bench for diff_pair_receiver.
module tb_diff_pair_receiver;
  localparam int WIDTH   = 8;
  localparam int HOLD    = 4;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             rst_n, pair_p, pair_n, data_ready, clr_overflow;
  logic [WIDTH-1:0] data;
  logic             data_valid, overflow, frame_err, fault_err;

  int n_checks = 0;
  int n_pass   = 0;
  int words = 0, vld_cycles = 0, frames = 0, faults = 0;
  logic [WIDTH-1:0] got_word = '0;

  always #5 clk = ~clk;

  diff_pair_receiver #(.WIDTH(WIDTH), .HOLD(HOLD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .pair_p(pair_p), .pair_n(pair_n),
    .data(data), .data_valid(data_valid), .data_ready(data_ready),
    .overflow(overflow), .clr_overflow(clr_overflow),
    .frame_err(frame_err), .fault_err(fault_err)
  );

  // Observe handshakes and error pulses mid-cycle
  always @(negedge clk) begin
    if (data_valid) vld_cycles++;
    if (data_valid && data_ready) begin
      got_word = data;
      words++;
    end
    if (frame_err) frames++;
    if (fault_err) faults++;
  end

  // Stimulus changes land 1 time unit after the rising edge
  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic p, input logic n, input int k);
    pair_p = p;
    pair_n = n;
    step(k);
  endtask

  task automatic send_bit(input logic b);
    drive(b, ~b, HOLD);
    drive(1'b0, 1'b0, HOLD);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++) send_bit(w[i]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pair_p = 1'b0; pair_n = 1'b0;
    data_ready = 1'b1; clr_overflow = 1'b0;
    step(3);
    n_checks++; if (data !== 8'h00) $display("FAIL reset_data: got %h want 00", data); else n_pass++;
    n_checks++; if (data_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", data_valid); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
    n_checks++; if (frame_err !== 1'b0) $display("FAIL reset_frame: got %b want 0", frame_err); else n_pass++;
    n_checks++; if (fault_err !== 1'b0) $display("FAIL reset_fault: got %b want 0", fault_err); else n_pass++;
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_basic();
    int w0, v0, f0, q0;
    logic [WIDTH-1:0] w;
    w = 8'hA5;
    w0 = words; v0 = vld_cycles; f0 = frames; q0 = faults;
    for (int i = 0; i < WIDTH - 1; i++) send_bit(w[i]);
    // Final bit: valid must appear 2 + HOLD + 1 edges after the pin change
    drive(w[WIDTH-1], ~w[WIDTH-1], HOLD);
    drive(1'b0, 1'b0, 2);
    n_checks++; if (data_valid !== 1'b0) $display("FAIL basic_valid_early: got %b want 0", data_valid); else n_pass++;
    step(1);
    n_checks++; if (data_valid !== 1'b1) $display("FAIL basic_valid_rise: got %b want 1", data_valid); else n_pass++;
    n_checks++; if (data !== 8'hA5) $display("FAIL basic_data: got %h want a5", data); else n_pass++;
    step(1);
    n_checks++; if (data_valid !== 1'b0) $display("FAIL basic_valid_fall: got %b want 0", data_valid); else n_pass++;
    step(HOLD);
    n_checks++; if (words - w0 !== 1) $display("FAIL basic_words: got %0d want 1", words - w0); else n_pass++;
    n_checks++; if (vld_cycles - v0 !== 1) $display("FAIL basic_valid_len: got %0d want 1", vld_cycles - v0); else n_pass++;
    n_checks++; if (frames !== f0 || faults !== q0) $display("FAIL basic_errors: got %0d/%0d want 0/0", frames - f0, faults - q0); else n_pass++;
  endtask

  task automatic test_glitch();
    int w0, f0, q0;
    w0 = words; f0 = frames; q0 = faults;
    drive(1'b1, 1'b0, HOLD - 1);
    drive(1'b0, 1'b1, HOLD - 1);
    drive(1'b0, 1'b0, HOLD);
    send_word(8'hFF);
    step(2);
    n_checks++; if (got_word !== 8'hFF) $display("FAIL glitch_data: got %h want ff", got_word); else n_pass++;
    n_checks++; if (words - w0 !== 1) $display("FAIL glitch_words: got %0d want 1", words - w0); else n_pass++;
    n_checks++; if (frames !== f0 || faults !== q0) $display("FAIL glitch_errors: got %0d/%0d want 0/0", frames - f0, faults - q0); else n_pass++;
  endtask

  task automatic test_timeout();
    int w0, f0;
    w0 = words; f0 = frames;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    drive(1'b0, 1'b0, TIMEOUT + 16);
    n_checks++; if (frames - f0 !== 1) $display("FAIL timeout_pulse: got %0d want 1", frames - f0); else n_pass++;
    n_checks++; if (words !== w0) $display("FAIL timeout_no_word: got %0d want 0", words - w0); else n_pass++;
    send_word(8'h3C);
    step(2);
    n_checks++; if (got_word !== 8'h3C) $display("FAIL timeout_next_data: got %h want 3c", got_word); else n_pass++;
    n_checks++; if (words - w0 !== 1) $display("FAIL timeout_next_words: got %0d want 1", words - w0); else n_pass++;
    n_checks++; if (frames - f0 !== 1) $display("FAIL timeout_single: got %0d want 1", frames - f0); else n_pass++;
  endtask

  task automatic test_fault();
    int w0, q0;
    w0 = words; q0 = faults;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    drive(1'b1, 1'b1, HOLD);
    drive(1'b0, 1'b0, HOLD);
    n_checks++; if (faults - q0 !== 1) $display("FAIL fault_pulse: got %0d want 1", faults - q0); else n_pass++;
    send_word(8'h81);
    step(2);
    n_checks++; if (got_word !== 8'h81) $display("FAIL fault_next_data: got %h want 81", got_word); else n_pass++;
    n_checks++; if (words - w0 !== 1) $display("FAIL fault_next_words: got %0d want 1", words - w0); else n_pass++;
  endtask

  task automatic test_backpressure();
    int w0;
    w0 = words;
    data_ready = 1'b0;
    send_word(8'h11);
    send_word(8'h22);
    step(2);
    n_checks++; if (data_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", data_valid); else n_pass++;
    n_checks++; if (data !== 8'h11) $display("FAIL bp_data_held: got %h want 11", data); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL bp_overflow: got %b want 1", overflow); else n_pass++;
    data_ready = 1'b1;
    step(1);
    n_checks++; if (data_valid !== 1'b0) $display("FAIL bp_valid_drop: got %b want 0", data_valid); else n_pass++;
    n_checks++; if (got_word !== 8'h11) $display("FAIL bp_consumed: got %h want 11", got_word); else n_pass++;
    n_checks++; if (words - w0 !== 1) $display("FAIL bp_words: got %0d want 1", words - w0); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL bp_sticky: got %b want 1", overflow); else n_pass++;
    clr_overflow = 1'b1;
    step(1);
    clr_overflow = 1'b0;
    n_checks++; if (overflow !== 1'b0) $display("FAIL bp_clear: got %b want 0", overflow); else n_pass++;
  endtask

  task automatic test_reset_mid_word();
    int w0, f0, q0;
    w0 = words; f0 = frames; q0 = faults;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    drive(1'b1, 1'b0, 2);
    rst_n = 1'b0;
    #1;
    n_checks++; if (data !== 8'h00) $display("FAIL midrst_data: got %h want 00", data); else n_pass++;
    n_checks++; if (data_valid !== 1'b0 || overflow !== 1'b0) $display("FAIL midrst_flags: got %b%b want 00", data_valid, overflow); else n_pass++;
    pair_p = 1'b0; pair_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    send_word(8'h5A);
    step(2);
    n_checks++; if (got_word !== 8'h5A) $display("FAIL midrst_data_after: got %h want 5a", got_word); else n_pass++;
    n_checks++; if (words - w0 !== 1) $display("FAIL midrst_words: got %0d want 1", words - w0); else n_pass++;
    n_checks++; if (frames !== f0 || faults !== q0) $display("FAIL midrst_errors: got %0d/%0d want 0/0", frames - f0, faults - q0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_timeout();
    test_fault();
    test_backpressure();
    test_reset_mid_word();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
